// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Gray/binary conversions work on a 32-bit word; callers size-cast to their pointer width.
package fifo_pkg;

    localparam int unsigned PTR_WORD_W = 32;

    typedef logic [PTR_WORD_W-1:0] ptr_word_t;

    // One extra pointer bit beyond the address distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; leading zeros of a narrow pointer are harmless.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = gray;
        for (int unsigned s = 1; s < PTR_WORD_W; s = s << 1) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_counter.sv
// Binary/Gray pointer register pair with increment enable; shared by the
// write-full and read-empty pointer generators.
module gray_ptr_counter
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray_next,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-2:0] addr
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    always_comb begin
        bin_d  = bin_q + WIDTH'(inc);
        gray_d = WIDTH'(bin2gray(ptr_word_t'(bin_d)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_next  = bin_d;
    assign gray_next = gray_d;
    assign gray      = gray_q;
    assign addr      = bin_q[WIDTH-2:0];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag, level and overflow for the asynchronous FIFO.
// Optional almost-full flag is built only when FIFO_AFULL_EN is defined.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow,
    output logic                  afull
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_full: AFULL_THRESH must lie in 1..2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] wgray;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] rgray_full;

    logic             wfull_q;
    logic             wfull_d;
    logic [PTR_W-1:0] wlevel_q;
    logic [PTR_W-1:0] wlevel_d;
    logic             overflow_q;
    logic             overflow_d;

    assign wen = winc & ~wfull_q;

    gray_ptr_counter #(
        .WIDTH (PTR_W)
    ) u_wptr (
        .clk       (clk),
        .rstn      (rstn),
        .inc       (wen),
        .bin_next  (wbin_next),
        .gray_next (wgray_next),
        .gray      (wgray),
        .addr      (waddr)
    );

    // Full when next write pointer has lapped the read pointer by one depth:
    // in Gray code that is the read pointer with its top two bits inverted.
    always_comb begin
        rbin_s     = PTR_W'(gray2bin(ptr_word_t'(rptr_sync)));
        rgray_full = {~rptr_sync[ADDR_WIDTH -: 2], rptr_sync[ADDR_WIDTH-2:0]};
        wfull_d    = (wgray_next == rgray_full);
        wlevel_d   = wbin_next - rbin_s;
        overflow_d = overflow_q | (winc & wfull_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wfull_q    <= 1'b0;
            wlevel_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wfull_q    <= wfull_d;
            wlevel_q   <= wlevel_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FIFO_AFULL_EN
    logic afull_q;
    logic afull_d;

    always_comb begin
        afull_d = (wlevel_d >= PTR_W'(AFULL_THRESH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign afull = afull_q;
`else
    assign afull = 1'b0;
`endif

    assign wptr     = wgray;
    assign wfull    = wfull_q;
    assign wlevel   = wlevel_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed and randomized bench for fifo_wptr_full against a count-based FIFO model.
module tb_fifo_wptr_full;

    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int THRESH = 60;
`ifdef FIFO_AFULL_EN
    localparam bit AFULL_ON = 1'b1;
`else
    localparam bit AFULL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          winc;
    logic [AW:0]   rptr_sync;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic [AW:0]   wlevel;
    logic          overflow;
    logic          afull;

    always #5 clk = ~clk;

    fifo_wptr_full #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .winc      (winc),
        .rptr_sync (rptr_sync),
        .wen       (wen),
        .waddr     (waddr),
        .wptr      (wptr),
        .wfull     (wfull),
        .wlevel    (wlevel),
        .overflow  (overflow),
        .afull     (afull)
    );

    int checks   = 0;
    int failures = 0;

    // Model: total writes accepted and read count seen, as plain integers.
    int m_wc   = 0;
    int m_rc   = 0;
    int m_lvl  = 0;
    bit m_full = 1'b0;
    bit m_over = 1'b0;

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string ph);
        chk({ph, ".waddr"},    32'(waddr),    32'(m_wc % DEPTH));
        chk({ph, ".wptr"},     32'(wptr),     32'(to_gray(m_wc)));
        chk({ph, ".wfull"},    32'(wfull),    32'(m_full));
        chk({ph, ".wlevel"},   32'(wlevel),   32'(m_lvl));
        chk({ph, ".overflow"}, 32'(overflow), 32'(m_over));
        chk({ph, ".afull"},    32'(afull),    32'(AFULL_ON && (m_lvl >= THRESH)));
    endtask

    task automatic model_reset();
        m_wc   = 0;
        m_rc   = 0;
        m_lvl  = 0;
        m_full = 1'b0;
        m_over = 1'b0;
    endtask

    // One write-clock cycle: drive at negedge, check wen, then registers after the edge.
    task automatic step(input bit w, input int r);
        @(negedge clk);
        winc      = w;
        m_rc      = r;
        rptr_sync = to_gray(r);
        #1;
        chk("wen", 32'(wen), 32'(w && !m_full));
        @(posedge clk);
        #1;
        m_over = m_over | (w && m_full);
        if (w && !m_full) m_wc++;
        m_lvl  = (m_wc - m_rc) % (2 * DEPTH);
        m_full = (m_lvl == DEPTH);
        check_regs("step");
    endtask

    task automatic async_reset();
        @(negedge clk);
        winc = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        @(posedge clk);
        #1;
        check_regs("rst_hold");
        @(negedge clk);
        winc      = 1'b0;
        rptr_sync = '0;
        rstn      = 1'b1;
    endtask

    initial begin
        logic [AW:0] prev_wptr;
        int          wraps;
        int          r;

        rstn      = 1'b0;
        winc      = 1'b0;
        rptr_sync = '0;
        #12;
        check_regs("por");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b1, 0);
        async_reset();

        step(1'b1, 0);
        chk("first.waddr", 32'(waddr), 32'd1);
        chk("first.wptr",  32'(wptr),  32'h01);

        for (int i = 0; i < 63; i++) step(1'b1, 0);
        chk("fill.wfull",  32'(wfull),  32'd1);
        chk("fill.wptr",   32'(wptr),   32'h60);
        chk("fill.wlevel", 32'(wlevel), 32'd64);

        step(1'b1, 0);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.wptr", 32'(wptr),     32'h60);

        step(1'b0, 1);
        chk("unfull.wfull",  32'(wfull),    32'd0);
        chk("unfull.wlevel", 32'(wlevel),   32'd63);
        chk("unfull.ovf",    32'(overflow), 32'd1);
        @(negedge clk);
        chk("unfull.addr_pre", 32'(waddr), 32'd0);
        step(1'b1, 1);
        chk("unfull.addr_post", 32'(waddr), 32'd1);

        async_reset();
        wraps = 0;
        for (int i = 0; i < 300; i++) begin
            prev_wptr = wptr;
            r = (m_wc >= 2) ? m_wc - 2 : 0;
            step(1'b1, r);
            chk("wrap.onebit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
            chk("wrap.nofull", 32'(wfull), 32'd0);
            chk("wrap.lvl_le3", 32'(wlevel <= 7'd3), 32'd1);
            if (waddr == '0) wraps++;
        end
        chk("wrap.count", 32'(wraps), 32'd4);

        // Random traffic: slow reader first so the FIFO fills, then a fast reader.
        for (int i = 0; i < 600; i++) begin
            r = m_rc;
            if ($urandom_range(0, (i < 300) ? 5 : 1) == 0) r = r + int'($urandom_range(1, 3));
            if (r > m_wc) r = m_wc;
            step(1'($urandom_range(0, 3) != 0), r);
        end

        async_reset();
        for (int i = 0; i < THRESH - 1; i++) step(1'b1, 0);
        chk("afull.below", 32'(afull), 32'd0);
        step(1'b1, 0);
        chk("afull.at", 32'(afull), 32'(AFULL_ON));
        step(1'b0, 1);
        chk("afull.read", 32'(afull), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
